// File: rtl/stream_pkg.sv
// Shared FSM state type and coordinate-width helper for the stream framer.
package stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int unsigned FLAG_W = 3;

    function automatic int unsigned coord_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_skid.sv
// Two-entry skid buffer: output register plus one overflow register.
module stream_skid #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_skid_full,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;

    // Upstream is held off whenever the skid entry is occupied, so push and
    // skid_valid are never both set here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || i_ready) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= i_push;
                if (i_push) begin
                    r_out_data <= i_data;
                end
            end
        end else if (i_push) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign o_skid_full = r_skid_valid;
    assign o_data      = r_out_data;
    assign o_valid     = r_out_valid;

endmodule

// File: rtl/stream_framer.sv
// Pixel stream framer: tags pixels with coordinates and frame/line flags,
// optionally zeroes a border band, and buffers them through a 2-entry skid.
module stream_framer
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned IMG_W  = 1920,
    parameter int unsigned IMG_H  = 1080,
    parameter int unsigned BORDER = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_en,
    input  logic                      border_zero_en,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         data_m,
    input  logic                      valid_m,
    output logic                      ready_m,
    output logic [DATA_W-1:0]         data_s,
    output logic                      valid_s,
    input  logic                      ready_s,
    output logic                      sof_s,
    output logic                      eol_s,
    output logic                      eof_s,
    output logic [coord_w(IMG_W)-1:0] x_s,
    output logic [coord_w(IMG_H)-1:0] y_s,
    output logic [15:0]               frame_cnt,
    output logic                      busy
);

    localparam int unsigned XW    = coord_w(IMG_W);
    localparam int unsigned YW    = coord_w(IMG_H);
    localparam int unsigned PAY_W = DATA_W + FLAG_W + XW + YW;

    state_t             r_state;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [15:0]        r_frame_cnt;

    logic               w_skid_full;
    logic               w_push;
    logic               w_last_x;
    logic               w_last_y;
    logic               w_mask;
    logic [DATA_W-1:0]  w_pix;
    logic [PAY_W-1:0]   w_pay_in;
    logic [PAY_W-1:0]   w_pay_out;

    assign ready_m  = (r_state == ACTIVE) && !w_skid_full;
    assign w_push   = valid_m && ready_m && !flush;
    assign w_last_x = (r_x == XW'(IMG_W - 1));
    assign w_last_y = (r_y == YW'(IMG_H - 1));

    // Mask and flags are resolved at input transfer so they travel with the pixel.
    assign w_mask = border_zero_en &&
                    ((32'(r_x) < BORDER) || (32'(r_x) >= IMG_W - BORDER) ||
                     (32'(r_y) < BORDER) || (32'(r_y) >= IMG_H - BORDER));
    assign w_pix    = w_mask ? '0 : data_m;
    assign w_pay_in = {w_pix, (r_x == '0) && (r_y == '0), w_last_x,
                       w_last_x && w_last_y, r_x, r_y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_en) begin
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_push) begin
                        if (w_last_x) begin
                            r_x <= '0;
                            if (w_last_y) begin
                                r_y         <= '0;
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                                if (!frame_en) begin
                                    r_state <= IDLE;
                                end
                            end else begin
                                r_y <= r_y + YW'(1);
                            end
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    stream_skid #(
        .W (PAY_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_data      (w_pay_in),
        .o_skid_full (w_skid_full),
        .o_data      (w_pay_out),
        .o_valid     (valid_s),
        .i_ready     (ready_s)
    );

    assign {data_s, sof_s, eol_s, eof_s, x_s, y_s} = w_pay_out;
    assign frame_cnt = r_frame_cnt;
    assign busy      = (r_state == ACTIVE);

endmodule

// File: tb/tb_stream_framer.sv
// Directed bench for stream_framer on an 8x4 image with a 1-pixel border.
module tb_stream_framer;

    localparam int unsigned DW = 24;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_en;
    logic          border_zero_en;
    logic          flush;
    logic [DW-1:0] data_m;
    logic          valid_m;
    logic          ready_m;
    logic [DW-1:0] data_s;
    logic          valid_s;
    logic          ready_s;
    logic          sof_s;
    logic          eol_s;
    logic          eof_s;
    logic [2:0]    x_s;
    logic [1:0]    y_s;
    logic [15:0]   frame_cnt;
    logic          busy;

    int unsigned   total = 0;
    int unsigned   bad = 0;
    int unsigned   in_tot = 0;
    int unsigned   cyc = 0;
    int unsigned   s_in = 0;
    int unsigned   s_out = 0;
    int unsigned   busy_drop = 0;
    bit            chk_busy = 1'b0;
    logic [31:0]   out_q[$];
    int unsigned   out_cyc[$];

    stream_framer #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H),
        .BORDER (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_en       (frame_en),
        .border_zero_en (border_zero_en),
        .flush          (flush),
        .data_m         (data_m),
        .valid_m        (valid_m),
        .ready_m        (ready_m),
        .data_s         (data_s),
        .valid_s        (valid_s),
        .ready_s        (ready_s),
        .sof_s          (sof_s),
        .eol_s          (eol_s),
        .eof_s          (eof_s),
        .x_s            (x_s),
        .y_s            (y_s),
        .frame_cnt      (frame_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Records transfers that will occur on the coming rising edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (valid_m && ready_m && !flush) in_tot <= in_tot + 1;
            if (valid_s && ready_s) begin
                out_q.push_back({data_s, sof_s, eol_s, eof_s, x_s, y_s});
                out_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [31:0] exp_word(input int unsigned i, input logic [DW-1:0] d);
        int unsigned p;
        int unsigned x;
        int unsigned y;
        p = i % (W * H);
        x = p % W;
        y = p / W;
        return {d, p == 0, x == W - 1, p == W * H - 1, 3'(x), 2'(y)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pump(input int unsigned target, input bit rnd, input int unsigned fe_until,
                        input logic [DW-1:0] base, input bit ones);
        int unsigned idx;
        int unsigned k;
        k = 0;
        idx = in_tot - s_in;
        while (idx < target && k < 3000) begin
            frame_en = (idx < fe_until);
            valid_m  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            data_m   = ones ? 24'hFFFFFF : base + 24'(idx);
            step();
            k++;
            idx = in_tot - s_in;
            if (chk_busy && idx > 0 && idx < target && !busy) busy_drop++;
        end
        valid_m  = 1'b0;
        frame_en = 1'b0;
        total++;
        if (idx != target) begin
            bad++;
            $display("FAIL pump_accepted got=%0d exp=%0d", idx, target);
        end
    endtask

    task automatic wait_out(input int unsigned n);
        int unsigned k;
        k = 0;
        while (out_q.size() - s_out < n && k < 300) begin
            step();
            k++;
        end
        total++;
        if (out_q.size() - s_out != n) begin
            bad++;
            $display("FAIL drain_count got=%0d exp=%0d", out_q.size() - s_out, n);
        end
    endtask

    task automatic mark();
        s_in  = in_tot;
        s_out = out_q.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_en = 1'b0; border_zero_en = 1'b0; flush = 1'b0;
        data_m = '0; valid_m = 1'b0; ready_s = 1'b1;
        repeat (3) step();
        total++;
        if ({valid_s, ready_m, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=000", {valid_s, ready_m, busy});
        end
        total++;
        if ({data_s, sof_s, eol_s, eof_s, x_s, y_s, frame_cnt} !== 48'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {data_s, sof_s, eol_s, eof_s, x_s, y_s, frame_cnt});
        end
        rst_n = 1'b1;
        step();
        total++;
        if (ready_m !== 1'b0) begin
            bad++;
            $display("FAIL idle_ready got=%b exp=0", ready_m);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] e;
        mark();
        pump(32, 1'b1, 1, 24'h010000, 1'b0);
        wait_out(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_word(j, 24'h010000 + 24'(j));
            total++;
            if (out_q[s_out + j] !== e) begin
                bad++;
                $display("FAIL basic_px%0d got=%h exp=%h", j, out_q[s_out + j], e);
            end
        end
        total++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_cnt got=%0d/%b exp=1/0", frame_cnt, busy);
        end
    endtask

    task automatic test_stall();
        int unsigned a;
        logic [31:0] e;
        mark();
        pump(3, 1'b0, 1, 24'h020000, 1'b0);
        ready_s = 1'b0;
        a = in_tot;
        for (int k = 0; k < 10; k++) begin
            valid_m = 1'b1;
            data_m  = 24'h020000 + 24'(in_tot - s_in);
            step();
        end
        valid_m = 1'b0;
        total++;
        if (in_tot - a > 2) begin
            bad++;
            $display("FAIL stall_accepts got=%0d exp<=2", in_tot - a);
        end
        total++;
        if (ready_m !== 1'b0 || valid_s !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold got=%b%b exp=01", ready_m, valid_s);
        end
        ready_s = 1'b1;
        pump(32, 1'b0, 0, 24'h020000, 1'b0);
        wait_out(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_word(j, 24'h020000 + 24'(j));
            total++;
            if (out_q[s_out + j] !== e) begin
                bad++;
                $display("FAIL stall_px%0d got=%h exp=%h", j, out_q[s_out + j], e);
            end
        end
        total++;
        if (frame_cnt !== 16'd2) begin
            bad++;
            $display("FAIL stall_cnt got=%0d exp=2", frame_cnt);
        end
    endtask

    task automatic test_border();
        logic [31:0] e;
        int unsigned x;
        int unsigned y;
        int unsigned inner;
        inner = 0;
        mark();
        border_zero_en = 1'b1;
        pump(32, 1'b0, 1, 24'h0, 1'b1);
        border_zero_en = 1'b0;
        wait_out(32);
        for (int j = 0; j < 32; j++) begin
            x = j % W;
            y = j / W;
            e = exp_word(j, (x == 0 || x == W - 1 || y == 0 || y == H - 1) ? 24'h0 : 24'hFFFFFF);
            if (out_q[s_out + j][31:8] === 24'hFFFFFF) inner++;
            total++;
            if (out_q[s_out + j] !== e) begin
                bad++;
                $display("FAIL border_px%0d got=%h exp=%h", j, out_q[s_out + j], e);
            end
        end
        total++;
        if (inner != 12) begin
            bad++;
            $display("FAIL border_inner got=%0d exp=12", inner);
        end
    endtask

    task automatic test_flush();
        logic [31:0] e;
        mark();
        pump(13, 1'b0, 1, 24'h030000, 1'b0);
        valid_m = 1'b1;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        valid_m = 1'b0;
        total++;
        if (valid_s !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_valid got=%b%b exp=00", valid_s, busy);
        end
        total++;
        if (frame_cnt !== 16'd3) begin
            bad++;
            $display("FAIL flush_cnt got=%0d exp=3", frame_cnt);
        end
        step();
        mark();
        pump(32, 1'b0, 1, 24'h040000, 1'b0);
        wait_out(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_word(j, 24'h040000 + 24'(j));
            total++;
            if (out_q[s_out + j] !== e) begin
                bad++;
                $display("FAIL flush_px%0d got=%h exp=%h", j, out_q[s_out + j], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        mark();
        busy_drop = 0;
        chk_busy  = 1'b1;
        pump(96, 1'b0, 80, 24'h050000, 1'b0);
        chk_busy  = 1'b0;
        wait_out(96);
        total++;
        if (busy_drop != 0) begin
            bad++;
            $display("FAIL b2b_busy got=%0d drops exp=0", busy_drop);
        end
        for (int j = 0; j < 96; j++) begin
            e = exp_word(j, 24'h050000 + 24'(j));
            total++;
            if (out_q[s_out + j] !== e) begin
                bad++;
                $display("FAIL b2b_px%0d got=%h exp=%h", j, out_q[s_out + j], e);
            end
        end
        for (int f = 1; f < 3; f++) begin
            total++;
            if (out_cyc[s_out + 32 * f] != out_cyc[s_out + 32 * f - 1] + 1) begin
                bad++;
                $display("FAIL b2b_gap%0d got=%0d exp=1", f,
                         out_cyc[s_out + 32 * f] - out_cyc[s_out + 32 * f - 1]);
            end
        end
        total++;
        if (frame_cnt !== 16'd7 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cnt got=%0d/%b exp=7/0", frame_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        mark();
        pump(10, 1'b0, 1, 24'h060000, 1'b0);
        valid_m = 1'b1;
        rst_n   = 1'b0;
        #1;
        total++;
        if ({valid_s, ready_m, busy} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_ctrl got=%b exp=000", {valid_s, ready_m, busy});
        end
        total++;
        if ({data_s, sof_s, eol_s, eof_s, x_s, y_s, frame_cnt} !== 48'h0) begin
            bad++;
            $display("FAIL rstmid_data got=%h exp=0", {data_s, sof_s, eol_s, eof_s, x_s, y_s, frame_cnt});
        end
        valid_m = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        mark();
        pump(32, 1'b0, 1, 24'h070000, 1'b0);
        wait_out(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_word(j, 24'h070000 + 24'(j));
            total++;
            if (out_q[s_out + j] !== e) begin
                bad++;
                $display("FAIL rstmid_px%0d got=%h exp=%h", j, out_q[s_out + j], e);
            end
        end
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL rstmid_cnt got=%0d exp=1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_border();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel width in bits (RGB888).
REQ-002 SHALL have parameter IMG_W, default 1920, pixels per line.
REQ-003 SHALL have parameter IMG_H, default 1080, lines per frame.
REQ-004 SHALL have parameter BORDER, default 1, border band width in pixels for masking.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port frame_en, input, 1, permit start of a new frame.
REQ-008 SHALL have port border_zero_en, input, 1, force border-band pixels to zero.
REQ-009 SHALL have port flush, input, 1, synchronous abort of the current frame.
REQ-010 SHALL have port data_m, input, DATA_W, upstream pixel.
REQ-011 SHALL have port valid_m, input, 1, upstream valid.
REQ-012 SHALL have port ready_m, output, 1, upstream ready.
REQ-013 SHALL have port data_s, output, DATA_W, downstream pixel.
REQ-014 SHALL have port valid_s, output, 1, downstream valid.
REQ-015 SHALL have port ready_s, input, 1, downstream ready.
REQ-016 SHALL have ports sof_s, eol_s and eof_s, output, 1 each: first pixel of frame, last pixel of line, last pixel of frame; valid with valid_s.
REQ-017 SHALL have ports x_s and y_s, output, clog2(IMG_W) and clog2(IMG_H): pixel coordinates, valid with valid_s.
REQ-018 SHALL have port frame_cnt, output, 16, completed-frame count.
REQ-019 SHALL have port busy, output, 1, high in state ACTIVE.

Function
REQ-020 SHALL treat a transfer as valid&ready high on the same clk edge, on both sides.
REQ-021 SHALL hold data_s, valid_s and the sideband outputs stable while valid_s=1 and ready_s=0.
REQ-022 SHALL deliver each accepted pixel on the output exactly 1 cycle after its input transfer when ready_s=1, with no bubbles.
REQ-023 SHALL buffer pixels in a 2-entry skid: output register plus skid register.
REQ-024 SHALL drive ready_m as registered !skid_valid when in ACTIVE, and 0 in IDLE.
REQ-025 SHALL use FSM states IDLE and ACTIVE.
REQ-026 SHALL move IDLE->ACTIVE on the cycle after frame_en=1 is sampled.
REQ-027 SHALL move ACTIVE->IDLE on the input transfer of pixel (IMG_W-1, IMG_H-1) if frame_en=0; if frame_en=1 it SHALL stay ACTIVE and continue with the next frame at (0,0).
REQ-028 SHALL start the x counter at 0, increment it per input transfer, and wrap it at IMG_W-1 while incrementing y.
REQ-029 SHALL wrap y at IMG_H-1 to 0 and increment frame_cnt modulo 2^16 on that same transfer.
REQ-030 SHALL compute sof_s, eol_s and eof_s from the x/y values at input transfer, so they stay aligned with their pixel through the skid.
REQ-031 SHALL output zero for a pixel when border_zero_en=1 and x<BORDER, x>=IMG_W-BORDER, y<BORDER or y>=IMG_H-BORDER; coordinates and flags SHALL be unaffected.
REQ-032 SHALL sample border_zero_en per pixel at input transfer.
REQ-033 SHALL, on flush=1, clear both skid entries and the x and y counters, go to IDLE, deassert valid_s the next cycle, and leave frame_cnt unchanged.
REQ-034 SHALL let flush win over a simultaneous input transfer; that pixel is dropped.
REQ-035 SHALL pass BORDER=0 with no pixel masking.

Reset
REQ-036 SHALL, while rst_n=0, hold state IDLE, valid_s=0, ready_m=0, data_s=0, sof_s=0, eol_s=0, eof_s=0, x_s=0, y_s=0, frame_cnt=0, busy=0 and both skid valids=0.
REQ-037 SHALL, on reset assertion mid-frame, discard all buffered pixels and start the next frame at (0,0).

Structure
REQ-038 SHALL put the FSM state enum and the coordinate width functions in shared package stream_pkg.
REQ-039 SHALL implement the skid in sub-module stream_skid, parameterised by payload width (DATA_W + flags + coordinates).

Verification
REQ-040 SHALL test IMG_W=8, IMG_H=4 with random valid_m and ready_s=1: 32 pixels out in order, sof_s on pixel 0, eol_s on pixels 7, 15, 23, 31, eof_s on pixel 31, frame_cnt=1.
REQ-041 SHALL test ready_s stuck at 0 for 10 cycles mid-line: at most 2 pixels accepted, ready_m=0 afterwards, no loss or duplicate after release.
REQ-042 SHALL test border_zero_en=1, BORDER=1, with input all 24'hFFFFFF: rows 0 and 3 and columns 0 and 7 output 0, the 12 interior pixels output 24'hFFFFFF.
REQ-043 SHALL test flush after 13 pixels: valid_s=0 the next cycle, the next frame starts with sof_s at (0,0), frame_cnt unchanged.
REQ-044 SHALL test frame_en held at 1 for 3 frames: busy stays high, frame_cnt=3, and sof_s follows eof_s with no bubble when the stream is continuous.
REQ-045 SHALL test rst_n pulsed low mid-frame: all outputs equal their REQ-036 values while low, and the frame restarts cleanly.
